// File: rtl/gpu_pkg.sv
// Shared widths, resolution defaults and FSM encoding for the triangle setup path.
package gpu_pkg;

  localparam int unsigned H_RES_DEFAULT = 640;
  localparam int unsigned V_RES_DEFAULT = 400;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned COEF_W  = 12;
  localparam int unsigned CONST_W = 25;
  localparam int unsigned AREA_W  = 27;
  localparam int unsigned PROD_W  = 2 * COEF_W;

  localparam int unsigned ST_W = 4;

  typedef logic [ST_W-1:0]           state_t;
  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic signed [COEF_W-1:0]  coef_t;
  typedef logic signed [CONST_W-1:0] const_t;
  typedef logic signed [AREA_W-1:0]  area_t;

  typedef struct packed {
    coord_t min_x;
    coord_t max_x;
    coord_t min_y;
    coord_t max_y;
  } box_t;

  localparam state_t StIdle   = 4'd0;
  localparam state_t StBox    = 4'd1;
  localparam state_t StMul0   = 4'd2;
  localparam state_t StMul1   = 4'd3;
  localparam state_t StMul2   = 4'd4;
  localparam state_t StMul3   = 4'd5;
  localparam state_t StMul4   = 4'd6;
  localparam state_t StMul5   = 4'd7;
  localparam state_t StMul6   = 4'd8;
  localparam state_t StMul7   = 4'd9;
  localparam state_t StOrient = 4'd10;
  localparam state_t StOut    = 4'd11;

  // Unsigned coordinate reinterpreted as a non-negative coefficient-width operand.
  function automatic coef_t coord_s(coord_t v);
    return $signed({1'b0, v});
  endfunction

  function automatic coef_t coord_diff(coord_t p, coord_t q);
    return coord_s(p) - coord_s(q);
  endfunction

  function automatic coord_t clip_max(coord_t v, coord_t lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/min_max3.sv
// Combinational minimum and maximum of three unsigned coordinates.
module min_max3
  import gpu_pkg::*;
(
  input  logic [COORD_W-1:0] a_i,
  input  logic [COORD_W-1:0] b_i,
  input  logic [COORD_W-1:0] c_i,
  output logic [COORD_W-1:0] min_o,
  output logic [COORD_W-1:0] max_o
);

  logic [COORD_W-1:0] ab_min;
  logic [COORD_W-1:0] ab_max;

  assign ab_min = (a_i < b_i) ? a_i : b_i;
  assign ab_max = (a_i < b_i) ? b_i : a_i;
  assign min_o  = (c_i < ab_min) ? c_i : ab_min;
  assign max_o  = (c_i > ab_max) ? c_i : ab_max;

endmodule

// File: rtl/tri_setup.sv
// Triangle setup: bounding box, edge equations and orientation fix-up for one vertex
// triple at a time, using a single shared multiplier over eight cycles.
module tri_setup
  import gpu_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEFAULT,
  parameter int unsigned V_RES = V_RES_DEFAULT
) (
  input  logic                      I_CLK,
  input  logic                      I_RST_N,
  input  logic                      I_VTX_VALID,
  output logic                      O_VTX_READY,
  input  logic [COORD_W-1:0]        I_AX,
  input  logic [COORD_W-1:0]        I_AY,
  input  logic [COORD_W-1:0]        I_BX,
  input  logic [COORD_W-1:0]        I_BY,
  input  logic [COORD_W-1:0]        I_CX,
  input  logic [COORD_W-1:0]        I_CY,
  output logic                      O_TRI_VALID,
  input  logic                      I_TRI_READY,
  output logic [COORD_W-1:0]        O_MIN_X,
  output logic [COORD_W-1:0]        O_MAX_X,
  output logic [COORD_W-1:0]        O_MIN_Y,
  output logic [COORD_W-1:0]        O_MAX_Y,
  output logic signed [COEF_W-1:0]  O_A0,
  output logic signed [COEF_W-1:0]  O_A1,
  output logic signed [COEF_W-1:0]  O_A2,
  output logic signed [COEF_W-1:0]  O_B0,
  output logic signed [COEF_W-1:0]  O_B1,
  output logic signed [COEF_W-1:0]  O_B2,
  output logic signed [CONST_W-1:0] O_C0,
  output logic signed [CONST_W-1:0] O_C1,
  output logic signed [CONST_W-1:0] O_C2,
  output logic [7:0]                O_DROP_CNT
);

  localparam coord_t XLim = coord_t'(H_RES - 1);
  localparam coord_t YLim = coord_t'(V_RES - 1);

  state_t     state_q, state_d;
  logic       vtx_ready_q;
  logic       tri_valid_q;
  logic       hs_in, hs_out;

  coord_t     ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
  box_t       box_q, box_d;
  coord_t     x_min, x_max, y_min, y_max;
  coef_t      a0_q, b0_q, a1_q, b1_q, a2_q, b2_q;
  const_t     c0_q, c1_q, c2_q;
  area_t      acc_q;
  logic [7:0] drop_cnt_q;

  box_t       out_box_q;
  coef_t      out_a0_q, out_b0_q, out_a1_q, out_b1_q, out_a2_q, out_b2_q;
  const_t     out_c0_q, out_c1_q, out_c2_q;

  coef_t                    mul_a, mul_b;
  logic signed [PROD_W-1:0] prod;
  area_t                    prod_ext, acc_sum, c0_ext;

  logic area_neg, area_zero, box_bad, degen;

  assign hs_in  = I_VTX_VALID & vtx_ready_q;
  assign hs_out = tri_valid_q & I_TRI_READY;

  min_max3 u_mm_x (
    .a_i   (ax_q),
    .b_i   (bx_q),
    .c_i   (cx_q),
    .min_o (x_min),
    .max_o (x_max)
  );

  min_max3 u_mm_y (
    .a_i   (ay_q),
    .b_i   (by_q),
    .c_i   (cy_q),
    .min_o (y_min),
    .max_o (y_max)
  );

  always_comb begin
    box_d.min_x = x_min;
    box_d.max_x = clip_max(x_max, XLim);
    box_d.min_y = y_min;
    box_d.max_y = clip_max(y_max, YLim);
  end

  // Operand schedule: even MUL states start a dot product, odd ones finish it.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      StMul0: begin mul_a = a0_q; mul_b = coord_s(bx_q); end
      StMul1: begin mul_a = b0_q; mul_b = coord_s(by_q); end
      StMul2: begin mul_a = a1_q; mul_b = coord_s(cx_q); end
      StMul3: begin mul_a = b1_q; mul_b = coord_s(cy_q); end
      StMul4: begin mul_a = a2_q; mul_b = coord_s(ax_q); end
      StMul5: begin mul_a = b2_q; mul_b = coord_s(ay_q); end
      StMul6: begin mul_a = a0_q; mul_b = coord_s(ax_q); end
      StMul7: begin mul_a = b0_q; mul_b = coord_s(ay_q); end
      default: ;
    endcase
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = {{(AREA_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_sum  = acc_q + prod_ext;
  assign c0_ext   = {{(AREA_W - CONST_W){c0_q[CONST_W-1]}}, c0_q};

  assign area_neg  = acc_q[AREA_W-1];
  assign area_zero = (acc_q == '0);
  assign box_bad   = (box_q.min_x > box_q.max_x) || (box_q.min_y > box_q.max_y);
  assign degen     = area_zero | box_bad;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (hs_in) state_d = StBox;
      StBox:    state_d = StMul0;
      StMul0, StMul1, StMul2, StMul3, StMul4, StMul5, StMul6:
                state_d = state_q + 4'd1;
      StMul7:   state_d = StOrient;
      StOrient: state_d = degen ? StIdle : StOut;
      StOut:    if (hs_out) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q     <= StIdle;
      vtx_ready_q <= 1'b0;
      tri_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      vtx_ready_q <= (state_d == StIdle);
      // Valid follows the output registers by one cycle and drops on the handshake.
      tri_valid_q <= (state_q == StOut) && !hs_out;
      if (state_q == StOrient && degen && drop_cnt_q != 8'hFF) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      ax_q  <= '0;
      ay_q  <= '0;
      bx_q  <= '0;
      by_q  <= '0;
      cx_q  <= '0;
      cy_q  <= '0;
      box_q <= '0;
      a0_q  <= '0;
      b0_q  <= '0;
      a1_q  <= '0;
      b1_q  <= '0;
      a2_q  <= '0;
      b2_q  <= '0;
      c0_q  <= '0;
      c1_q  <= '0;
      c2_q  <= '0;
      acc_q <= '0;
    end else begin
      if (hs_in) begin
        ax_q <= I_AX;
        ay_q <= I_AY;
        bx_q <= I_BX;
        by_q <= I_BY;
        cx_q <= I_CX;
        cy_q <= I_CY;
      end
      unique case (state_q)
        StBox: begin
          box_q <= box_d;
          a0_q  <= coord_diff(by_q, cy_q);
          b0_q  <= coord_diff(cx_q, bx_q);
          a1_q  <= coord_diff(cy_q, ay_q);
          b1_q  <= coord_diff(ax_q, cx_q);
          a2_q  <= coord_diff(ay_q, by_q);
          b2_q  <= coord_diff(bx_q, ax_q);
        end
        StMul0, StMul2, StMul4, StMul6: acc_q <= prod_ext;
        StMul1: c0_q  <= const_t'(-acc_sum);
        StMul3: c1_q  <= const_t'(-acc_sum);
        StMul5: c2_q  <= const_t'(-acc_sum);
        // Edge 0 evaluated at vertex a: twice the signed triangle area.
        StMul7: acc_q <= acc_sum + c0_ext;
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      out_box_q <= '0;
      out_a0_q  <= '0;
      out_b0_q  <= '0;
      out_c0_q  <= '0;
      out_a1_q  <= '0;
      out_b1_q  <= '0;
      out_c1_q  <= '0;
      out_a2_q  <= '0;
      out_b2_q  <= '0;
      out_c2_q  <= '0;
    end else if (state_q == StOrient && !degen) begin
      out_box_q <= box_q;
      out_a0_q  <= area_neg ? -a0_q : a0_q;
      out_b0_q  <= area_neg ? -b0_q : b0_q;
      out_c0_q  <= area_neg ? -c0_q : c0_q;
      out_a1_q  <= area_neg ? -a1_q : a1_q;
      out_b1_q  <= area_neg ? -b1_q : b1_q;
      out_c1_q  <= area_neg ? -c1_q : c1_q;
      out_a2_q  <= area_neg ? -a2_q : a2_q;
      out_b2_q  <= area_neg ? -b2_q : b2_q;
      out_c2_q  <= area_neg ? -c2_q : c2_q;
    end
  end

  assign O_VTX_READY = vtx_ready_q;
  assign O_TRI_VALID = tri_valid_q;
  assign O_DROP_CNT  = drop_cnt_q;
  assign O_MIN_X     = out_box_q.min_x;
  assign O_MAX_X     = out_box_q.max_x;
  assign O_MIN_Y     = out_box_q.min_y;
  assign O_MAX_Y     = out_box_q.max_y;
  assign O_A0        = out_a0_q;
  assign O_B0        = out_b0_q;
  assign O_C0        = out_c0_q;
  assign O_A1        = out_a1_q;
  assign O_B1        = out_b1_q;
  assign O_C1        = out_c1_q;
  assign O_A2        = out_a2_q;
  assign O_B2        = out_b2_q;
  assign O_C2        = out_c2_q;

endmodule

// File: tb/tb_tri_setup.sv
// Bench for tri_setup: directed and random triples against a geometric reference model.
module tb_tri_setup;

  localparam int H = 640;
  localparam int V = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vtx_valid = 1'b0;
  logic tri_ready = 1'b1;
  logic [10:0] ax = '0, ay = '0, bx = '0, by = '0, cx = '0, cy = '0;
  logic vtx_ready, tri_valid;
  logic [10:0] min_x, max_x, min_y, max_y;
  logic signed [11:0] a0, a1, a2, b0, b1, b2;
  logic signed [24:0] c0, c1, c2;
  logic [7:0] drop_cnt;
  logic [198:0] out_bus;

  assign out_bus = {min_x, max_x, min_y, max_y, a0, a1, a2, b0, b1, b2, c0, c1, c2, drop_cnt};

  always #5 clk = ~clk;

  tri_setup #(.H_RES(H), .V_RES(V)) dut (
    .I_CLK       (clk),
    .I_RST_N     (rst_n),
    .I_VTX_VALID (vtx_valid),
    .O_VTX_READY (vtx_ready),
    .I_AX        (ax),
    .I_AY        (ay),
    .I_BX        (bx),
    .I_BY        (by),
    .I_CX        (cx),
    .I_CY        (cy),
    .O_TRI_VALID (tri_valid),
    .I_TRI_READY (tri_ready),
    .O_MIN_X     (min_x),
    .O_MAX_X     (max_x),
    .O_MIN_Y     (min_y),
    .O_MAX_Y     (max_y),
    .O_A0        (a0),
    .O_A1        (a1),
    .O_A2        (a2),
    .O_B0        (b0),
    .O_B1        (b1),
    .O_B2        (b2),
    .O_C0        (c0),
    .O_C1        (c1),
    .O_C2        (c2),
    .O_DROP_CNT  (drop_cnt)
  );

  typedef struct packed {
    int ax, ay, bx, by, cx, cy;
    bit drop;
    int min_x, max_x, min_y, max_y;
    int a0, b0, c0, a1, b1, c1, a2, b2, c2;
  } vec_t;

  int n_run = 0;
  int n_fail = 0;
  int drops = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int min3(int p, int q, int r);
    int m;
    m = (p < q) ? p : q;
    return (r < m) ? r : m;
  endfunction

  function automatic int max3(int p, int q, int r);
    int m;
    m = (p > q) ? p : q;
    return (r > m) ? r : m;
  endfunction

  // Edge equations from the vertex rules; orientation from the cross product.
  function automatic vec_t model(int xa, int ya, int xb, int yb, int xc, int yc);
    vec_t e;
    int area, s;
    e = '0;
    e.ax = xa; e.ay = ya; e.bx = xb; e.by = yb; e.cx = xc; e.cy = yc;
    area = (xb - xa) * (yc - ya) - (yb - ya) * (xc - xa);
    s = (area < 0) ? -1 : 1;
    e.a0 = s * (yb - yc);  e.b0 = s * (xc - xb);
    e.a1 = s * (yc - ya);  e.b1 = s * (xa - xc);
    e.a2 = s * (ya - yb);  e.b2 = s * (xb - xa);
    e.c0 = -(e.a0 * xb + e.b0 * yb);
    e.c1 = -(e.a1 * xc + e.b1 * yc);
    e.c2 = -(e.a2 * xa + e.b2 * ya);
    e.min_x = min3(xa, xb, xc);
    e.min_y = min3(ya, yb, yc);
    e.max_x = max3(xa, xb, xc);
    e.max_y = max3(ya, yb, yc);
    if (e.max_x > H - 1) e.max_x = H - 1;
    if (e.max_y > V - 1) e.max_y = V - 1;
    e.drop = (area == 0) || (e.min_x > e.max_x) || (e.min_y > e.max_y);
    return e;
  endfunction

  function automatic vec_t mk(int xa, int ya, int xb, int yb, int xc, int yc, bit d,
                              int mnx, int mxx, int mny, int mxy,
                              int ea0, int eb0, int ec0, int ea1, int eb1, int ec1,
                              int ea2, int eb2, int ec2);
    vec_t e;
    e.ax = xa; e.ay = ya; e.bx = xb; e.by = yb; e.cx = xc; e.cy = yc;
    e.drop = d;
    e.min_x = mnx; e.max_x = mxx; e.min_y = mny; e.max_y = mxy;
    e.a0 = ea0; e.b0 = eb0; e.c0 = ec0;
    e.a1 = ea1; e.b1 = eb1; e.c1 = ec1;
    e.a2 = ea2; e.b2 = eb2; e.c2 = ec2;
    return e;
  endfunction

  // Present a triple and wait for the accepting edge; returns just after that edge.
  task automatic send(input vec_t e, output bit ok, output int waits);
    bit rdy;
    ax = 11'(e.ax); ay = 11'(e.ay);
    bx = 11'(e.bx); by = 11'(e.by);
    cx = 11'(e.cx); cy = 11'(e.cy);
    vtx_valid = 1'b1;
    ok = 1'b0;
    waits = -1;
    for (int i = 0; i < 50; i++) begin
      rdy = vtx_ready;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        waits = i;
        break;
      end
    end
    vtx_valid = 1'b0;
  endtask

  // Follow one triple from its handshake to completion; hold keeps I_TRI_READY low.
  task automatic collect(input vec_t e, input int hold);
    int cyc;
    bit got_valid;
    logic [198:0] snap;
    cyc = -1;
    got_valid = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (tri_valid) begin cyc = i; got_valid = 1'b1; break; end
      if (vtx_ready) begin cyc = i; break; end
    end
    if (e.drop) begin
      drops++;
      chk("drop_no_valid", longint'(got_valid), 0);
      chk("drop_ready_latency", cyc, 10);
      chk("drop_cnt", drop_cnt, (drops > 255) ? 255 : drops);
    end else begin
      chk("valid_latency", cyc, 11);
      chk("min_x", min_x, e.min_x);
      chk("max_x", max_x, e.max_x);
      chk("min_y", min_y, e.min_y);
      chk("max_y", max_y, e.max_y);
      chk("a0", a0, e.a0);  chk("b0", b0, e.b0);  chk("c0", c0, e.c0);
      chk("a1", a1, e.a1);  chk("b1", b1, e.b1);  chk("c1", c1, e.c1);
      chk("a2", a2, e.a2);  chk("b2", b2, e.b2);  chk("c2", c2, e.c2);
      snap = out_bus;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("hold_outputs_stable", longint'(out_bus == snap), 1);
        chk("hold_valid", tri_valid, 1);
        chk("hold_vtx_ready_low", vtx_ready, 0);
      end
      tri_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_hs_valid", tri_valid, 0);
      chk("post_hs_vtx_ready", vtx_ready, 1);
    end
  endtask

  initial begin
    vec_t tbl[$];
    vec_t e, v1;
    bit ok, seen;
    int waits;
    int r[6];

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vtx_ready", vtx_ready, 0);
    chk("rst_tri_valid", tri_valid, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_max_x", max_x, 0);
    chk("rst_a0", a0, 0);
    chk("rst_c2", c2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", vtx_ready, 1);

    v1 = mk(1, 1, 200, 100, 50, 50, 0, 1, 200, 1, 100,
            50, -150, 5000, 49, -49, 0, -99, 199, -100);
    tbl.push_back(v1);
    tbl.push_back(mk(1, 1, 50, 50, 200, 100, 0, 1, 200, 1, 100,
                     50, -150, 5000, -99, 199, -100, 49, -49, 0));
    tbl.push_back(mk(0, 0, 10, 10, 20, 20, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(100, 100, 700, 100, 100, 500, 0, 100, 639, 100, 399,
                     -400, -600, 340000, 400, 0, -40000, 0, 600, -60000));
    tbl.push_back(mk(700, 10, 800, 10, 700, 100, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(model(639, 399, 0, 0, 639, 0));
    tbl.push_back(model(2047, 2047, 0, 2047, 2047, 0));
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 6; k++) begin
        r[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047))
                                           : int'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 4) == 0) begin
        r[3] = r[1];
        r[5] = r[1];
      end
      tbl.push_back(model(r[0], r[1], r[2], r[3], r[4], r[5]));
    end

    foreach (tbl[i]) begin
      send(tbl[i], ok, waits);
      chk("accept", longint'(ok), 1);
      collect(tbl[i], 0);
    end

    // Back-pressure for five cycles, then an immediate follow-on triple
    tri_ready = 1'b0;
    e = model(100, 100, 700, 100, 100, 500);
    send(e, ok, waits);
    chk("accept_held", longint'(ok), 1);
    collect(e, 5);
    send(v1, ok, waits);
    chk("accept_next_cycle", waits, 0);
    collect(v1, 0);

    // Reset pulse while the multiplier sequence is in MUL3
    e = model(100, 100, 700, 100, 100, 500);
    send(e, ok, waits);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    drops = 0;
    #1;
    chk("midrst_tri_valid", tri_valid, 0);
    chk("midrst_vtx_ready", vtx_ready, 0);
    chk("midrst_a0", a0, 0);
    chk("midrst_c0", c0, 0);
    chk("midrst_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (tri_valid) seen = 1'b1;
    end
    chk("abort_no_valid", longint'(seen), 0);
    send(v1, ok, waits);
    chk("accept_after_rst", longint'(ok), 1);
    collect(v1, 0);

    // Drop counter saturation
    e = model(0, 0, 10, 10, 20, 20);
    for (int i = 0; i < 258; i++) begin
      send(e, ok, waits);
      collect(e, 0);
    end
    chk("drop_cnt_saturated", drop_cnt, 255);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
